// File: rtl/wb_timeout_slice.sv
// Registered Wishbone slice with a bus watchdog.
// Sits between an interconnect slave port and a single target. Each upstream
// beat is registered, replayed downstream as one classic cycle, and the
// target's answer is registered back. A target that never answers is
// converted into an ERR response after TIMEOUT_CYCLES, and such events are
// counted (saturating) and flagged (sticky) for software.
module wb_timeout_slice #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  // upstream port, driven by the interconnect
  input  logic                         i_s_cyc,
  input  logic                         i_s_stb,
  input  logic                         i_s_we,
  input  logic [WB_ADDR_WIDTH-1:0]     i_s_adr,
  input  logic [WB_DATA_WIDTH-1:0]     i_s_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0]   i_s_sel,
  input  logic [2:0]                   i_s_cti,
  input  logic [1:0]                   i_s_bte,
  output logic                         o_s_ack,
  output logic                         o_s_err,
  output logic [WB_DATA_WIDTH-1:0]     o_s_dat_r,
  // downstream port, drives the target
  output logic                         o_m_cyc,
  output logic                         o_m_stb,
  output logic                         o_m_we,
  output logic [WB_ADDR_WIDTH-1:0]     o_m_adr,
  output logic [WB_DATA_WIDTH-1:0]     o_m_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]   o_m_sel,
  output logic [2:0]                   o_m_cti,
  output logic [1:0]                   o_m_bte,
  input  logic                         i_m_ack,
  input  logic                         i_m_err,
  input  logic [WB_DATA_WIDTH-1:0]     i_m_dat_r,
  // watchdog visibility
  output logic [TO_CNT_WIDTH-1:0]      o_to_count,
  output logic                         o_to_flag,
  input  logic                         i_to_clr
);

  localparam int SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int WDOG_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WDOG_ON    = (TIMEOUT_CYCLES != 0);
  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
    WDOG_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [WDOG_WIDTH-1:0]     r_wdog;
  logic                      w_wdog_expired;

  logic                      r_we;
  logic [WB_ADDR_WIDTH-1:0]  r_adr;
  logic [WB_DATA_WIDTH-1:0]  r_dat_w;
  logic [SEL_WIDTH-1:0]      r_sel;
  logic [2:0]                r_cti;
  logic [1:0]                r_bte;

  logic                      r_rsp_err;
  logic [WB_DATA_WIDTH-1:0]  r_rsp_dat;

  logic [TO_CNT_WIDTH-1:0]   r_to_count;
  logic                      r_to_flag;

  logic                      w_req_load;
  logic                      w_rsp_load;
  logic                      w_rsp_err;
  logic [WB_DATA_WIDTH-1:0]  w_rsp_dat;
  logic                      w_timeout;

  assign w_wdog_expired = WDOG_ON && (r_wdog == WDOG_LAST);

  // State register.
  // NOTE: sequential blocks use <= so every flop samples pre-edge values,
  // independent of statement order or of other always blocks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus the load strobes for the request/response registers.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_req_load  = 1'b0;
    w_rsp_load  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_dat   = i_m_dat_r;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_s_cyc && i_s_stb) begin
          w_req_load  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!i_s_cyc) begin
          // master abort: drop the downstream cycle, answer nobody
          w_state_nxt = ST_IDLE;
        end else if (i_m_err) begin
          // ERR wins over a simultaneous ACK
          w_rsp_load  = 1'b1;
          w_rsp_err   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (i_m_ack) begin
          w_rsp_load  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_wdog_expired) begin
          w_rsp_load  = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_dat   = '0;
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the upstream beat on acceptance; held unchanged through REQ.
  // NOTE: these are plain flops, not a memory array, so they are reset to
  // give the downstream port defined zero values out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat_w <= '0;
      r_sel   <= '0;
      r_cti   <= '0;
      r_bte   <= '0;
    end else if (w_req_load) begin
      r_we    <= i_s_we;
      r_adr   <= i_s_adr;
      r_dat_w <= i_s_dat_w;
      r_sel   <= i_s_sel;
      r_cti   <= i_s_cti;
      r_bte   <= i_s_bte;
    end
  end

  // Capture the target (or watchdog) response; read data holds between beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_err <= 1'b0;
      r_rsp_dat <= '0;
    end else if (w_rsp_load) begin
      r_rsp_err <= w_rsp_err;
      r_rsp_dat <= w_rsp_dat;
    end
  end

  // Watchdog: restarts on every new request and counts cycles spent in REQ.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   r_wdog <= '0;
    else if (w_req_load)         r_wdog <= '0;
    else if (r_state == ST_REQ)  r_wdog <= r_wdog + WDOG_WIDTH'(1);
  end

  // Timeout statistics: a clear in the same cycle as a timeout drops the event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_count <= '0;
      r_to_flag  <= 1'b0;
    end else if (i_to_clr) begin
      r_to_count <= '0;
      r_to_flag  <= 1'b0;
    end else if (w_timeout) begin
      r_to_flag <= 1'b1;
      if (r_to_count != '1) r_to_count <= r_to_count + TO_CNT_WIDTH'(1);
    end
  end

  assign o_m_cyc    = (r_state == ST_REQ);
  assign o_m_stb    = (r_state == ST_REQ);
  assign o_m_we     = r_we;
  assign o_m_adr    = r_adr;
  assign o_m_dat_w  = r_dat_w;
  assign o_m_sel    = r_sel;
  assign o_m_cti    = r_cti;
  assign o_m_bte    = r_bte;

  assign o_s_ack    = (r_state == ST_RESP) && !r_rsp_err;
  assign o_s_err    = (r_state == ST_RESP) &&  r_rsp_err;
  assign o_s_dat_r  = r_rsp_dat;

  assign o_to_count = r_to_count;
  assign o_to_flag  = r_to_flag;

endmodule

// File: tb/tb_wb_timeout_slice.sv
// Self-checking bench for wb_timeout_slice: directed beats, randomized beats
// and a saturation run, all predicted by a per-beat behavioural model.
module tb_wb_timeout_slice;

  localparam int T       = 16;
  localparam int HANG    = 1000;   // wait count meaning "target never answers"
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [31:0] s_adr = '0, s_dat_w = '0;
  logic [3:0]  s_sel = '0;
  logic [2:0]  s_cti = '0;
  logic [1:0]  s_bte = '0;
  logic        s_ack, s_err;
  logic [31:0] s_dat_r;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_w;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        m_ack = 1'b0, m_err = 1'b0;
  logic [31:0] m_dat_r = '0;
  logic [7:0]  to_count;
  logic        to_flag;
  logic        to_clr = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int          mdl_count = 0;
  bit          mdl_flag  = 1'b0;
  logic [31:0] mdl_dat   = '0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    int          waits;     // REQ cycles before the target answers; >= T means hang
    int          rsp;       // 0 ACK, 1 ERR, 2 ACK+ERR
    logic [31:0] rdata;
    int          abort_at;  // REQ cycle in which the master drops CYC, -1 none
    int          clr_at;    // REQ cycle in which to_clr is pulsed, -1 none
  } beat_t;

  wb_timeout_slice #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES(T),
    .TO_CNT_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_s_cyc   (s_cyc),
    .i_s_stb   (s_stb),
    .i_s_we    (s_we),
    .i_s_adr   (s_adr),
    .i_s_dat_w (s_dat_w),
    .i_s_sel   (s_sel),
    .i_s_cti   (s_cti),
    .i_s_bte   (s_bte),
    .o_s_ack   (s_ack),
    .o_s_err   (s_err),
    .o_s_dat_r (s_dat_r),
    .o_m_cyc   (m_cyc),
    .o_m_stb   (m_stb),
    .o_m_we    (m_we),
    .o_m_adr   (m_adr),
    .o_m_dat_w (m_dat_w),
    .o_m_sel   (m_sel),
    .o_m_cti   (m_cti),
    .o_m_bte   (m_bte),
    .i_m_ack   (m_ack),
    .i_m_err   (m_err),
    .i_m_dat_r (m_dat_r),
    .o_to_count(to_count),
    .o_to_flag (to_flag),
    .i_to_clr  (to_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_cyc"},    m_cyc,    0);
    check({tag, "_m_stb"},    m_stb,    0);
    check({tag, "_m_we"},     m_we,     0);
    check({tag, "_m_adr"},    m_adr,    0);
    check({tag, "_m_dat_w"},  m_dat_w,  0);
    check({tag, "_m_sel"},    m_sel,    0);
    check({tag, "_m_cti"},    m_cti,    0);
    check({tag, "_m_bte"},    m_bte,    0);
    check({tag, "_s_ack"},    s_ack,    0);
    check({tag, "_s_err"},    s_err,    0);
    check({tag, "_s_dat_r"},  s_dat_r,  0);
    check({tag, "_to_count"}, to_count, 0);
    check({tag, "_to_flag"},  to_flag,  0);
  endtask

  function automatic beat_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                               input int waits, input int rsp, input logic [31:0] rdata,
                               input int abort_at, input int clr_at);
    beat_t b;
    b.we = we; b.adr = adr; b.dat = dat; b.sel = sel; b.cti = cti; b.bte = bte;
    b.waits = waits; b.rsp = rsp; b.rdata = rdata; b.abort_at = abort_at; b.clr_at = clr_at;
    return b;
  endfunction

  // Run one upstream beat and check it cycle by cycle against the model.
  task automatic run_beat(input string tag, input beat_t b);
    bit          aborted, timed_out;
    int          n_req;
    logic        exp_ack, exp_err;
    aborted   = (b.abort_at >= 0) && (b.abort_at < b.waits) && (b.abort_at < T);
    timed_out = !aborted && (b.waits >= T);
    if (aborted)        n_req = b.abort_at + 1;
    else if (timed_out) n_req = T;
    else                n_req = b.waits + 1;

    // request cycle: the beat is only sampled here, nothing downstream yet
    @(posedge clk); #1;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = b.we; s_adr = b.adr; s_dat_w = b.dat;
    s_sel = b.sel; s_cti = b.cti; s_bte = b.bte;
    @(negedge clk);
    check({tag, "_req_latency_m_stb"}, m_stb, 0);

    for (int k = 0; k < n_req; k++) begin
      @(posedge clk); #1;
      m_ack = 1'b0; m_err = 1'b0; to_clr = 1'b0; m_dat_r = $urandom();
      if (aborted && k == b.abort_at) begin
        s_cyc = 1'b0; s_stb = 1'b0;
      end
      if (!aborted && !timed_out && k == b.waits) begin
        m_ack   = (b.rsp != 1);
        m_err   = (b.rsp != 0);
        m_dat_r = b.rdata;
      end
      if (k == b.clr_at) to_clr = 1'b1;
      @(negedge clk);
      check({tag, "_req_m_cyc"}, m_cyc, 1);
      check({tag, "_req_m_stb"}, m_stb, 1);
      check({tag, "_req_s_ack"}, s_ack, 0);
      check({tag, "_req_s_err"}, s_err, 0);
      if (k == 0) begin
        check({tag, "_m_we"},    m_we,    b.we);
        check({tag, "_m_adr"},   m_adr,   b.adr);
        check({tag, "_m_dat_w"}, m_dat_w, b.dat);
        check({tag, "_m_sel"},   m_sel,   b.sel);
        check({tag, "_m_cti"},   m_cti,   b.cti);
        check({tag, "_m_bte"},   m_bte,   b.bte);
      end
    end

    @(posedge clk); #1;
    m_ack = 1'b0; m_err = 1'b0; to_clr = 1'b0; m_dat_r = $urandom();

    if (b.clr_at >= 0 && b.clr_at < n_req) begin
      mdl_count = 0;
      mdl_flag  = 1'b0;
    end
    if (timed_out && b.clr_at != n_req - 1) begin
      mdl_flag = 1'b1;
      if (mdl_count < CNT_MAX) mdl_count++;
    end
    if (aborted) begin
      exp_ack = 1'b0; exp_err = 1'b0;
    end else if (timed_out) begin
      exp_ack = 1'b0; exp_err = 1'b1; mdl_dat = '0;
    end else begin
      exp_ack = (b.rsp == 0); exp_err = (b.rsp != 0); mdl_dat = b.rdata;
    end

    @(negedge clk);
    check({tag, "_rsp_m_cyc"},    m_cyc,    0);
    check({tag, "_rsp_m_stb"},    m_stb,    0);
    check({tag, "_rsp_s_ack"},    s_ack,    exp_ack);
    check({tag, "_rsp_s_err"},    s_err,    exp_err);
    check({tag, "_rsp_s_dat_r"},  s_dat_r,  mdl_dat);
    check({tag, "_rsp_to_count"}, to_count, mdl_count);
    check({tag, "_rsp_to_flag"},  to_flag,  mdl_flag);

    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    check({tag, "_idle_s_ack"},   s_ack,   0);
    check({tag, "_idle_s_err"},   s_err,   0);
    check({tag, "_idle_s_dat_r"}, s_dat_r, mdl_dat);
    check({tag, "_idle_m_cyc"},   m_cyc,   0);
  endtask

  initial begin
    beat_t b;
    int    w, lim;

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // write, target ACKs after 2 waits
    run_beat("wr", mk(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd0, 2'd0, 2, 0, 32'h0, -1, -1));
    // read, zero-wait target
    run_beat("rd", mk(1'b0, 32'h104, 32'h0, 4'hF, 3'd0, 2'd0, 0, 0, 32'h12345678, -1, -1));
    // hung target -> watchdog ERR after T REQ cycles
    run_beat("hang", mk(1'b0, 32'h108, 32'h0, 4'h3, 3'd0, 2'd0, HANG, 0, 32'h0, -1, -1));
    // ACK exactly in the expiry cycle: target wins
    run_beat("ack_expiry", mk(1'b0, 32'h10C, 32'h0, 4'hF, 3'd0, 2'd0, T - 1, 0, 32'hA5A55A5A, -1, -1));
    // ACK+ERR together in the expiry cycle, burst tags forwarded
    run_beat("both_expiry", mk(1'b1, 32'h110, 32'h55AA, 4'h5, 3'b010, 2'b01, T - 1, 2, 32'h0BADF00D, -1, -1));
    // master abort mid-REQ, then a normal beat
    run_beat("abort", mk(1'b1, 32'h114, 32'h1, 4'hF, 3'd0, 2'd0, HANG, 0, 32'h0, 3, -1));
    run_beat("after_abort", mk(1'b0, 32'h118, 32'h0, 4'hF, 3'd0, 2'd0, 1, 0, 32'hCAFEF00D, -1, -1));
    // clear in the same cycle as a timeout: the event is lost
    run_beat("clr_expiry", mk(1'b0, 32'h11C, 32'h0, 4'hF, 3'd0, 2'd0, HANG, 0, 32'h0, -1, T - 1));
    // clear earlier in REQ, the later timeout still counts
    run_beat("clr_early", mk(1'b0, 32'h120, 32'h0, 4'hF, 3'd0, 2'd0, HANG, 0, 32'h0, -1, 5));

    // reset pulsed during REQ: everything returns to zero at once
    @(posedge clk); #1;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'h200; s_dat_w = 32'h77;
    s_sel = 4'hC; s_cti = 3'd1; s_bte = 2'd2;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_pre_m_cyc", m_cyc, 1);
    check("midrst_pre_to_count", to_count, mdl_count);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    mdl_count = 0; mdl_flag = 1'b0; mdl_dat = '0;
    s_cyc = 1'b0; s_stb = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_post_m_cyc", m_cyc, 0);
    check("midrst_post_s_ack", s_ack, 0);
    run_beat("post_rst", mk(1'b0, 32'h204, 32'h0, 4'hF, 3'd0, 2'd0, 3, 0, 32'h600DD00D, -1, -1));

    // randomized beats
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) w = HANG;
      else                           w = int'($urandom_range(0, T - 1));
      b = mk(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), w,
             int'($urandom_range(0, 2)), $urandom(), -1, -1);
      lim = (w < T - 1) ? w : T - 1;
      if (lim > 0 && $urandom_range(0, 5) == 0) b.abort_at = int'($urandom_range(0, lim - 1));
      if ($urandom_range(0, 7) == 0) b.clr_at = int'($urandom_range(0, T - 1));
      run_beat("rand", b);
    end

    // 300 timeouts: counter saturates
    for (int i = 0; i < 300; i++)
      run_beat("sat", mk(1'b0, 32'h300, 32'h0, 4'hF, 3'd0, 2'd0, HANG, 0, 32'h0, -1, -1));
    check("sat_to_count", to_count, CNT_MAX);
    check("sat_to_flag",  to_flag,  1);

    // standalone clear
    @(posedge clk); #1;
    to_clr = 1'b1;
    @(posedge clk); #1;
    to_clr = 1'b0;
    mdl_count = 0; mdl_flag = 1'b0;
    @(negedge clk);
    check("clr_to_count", to_count, mdl_count);
    check("clr_to_flag",  to_flag,  mdl_flag);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
